// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the CalcuTEC multicycle sequencer.
// master: the sequencer (drives enables/muxes, samples instruction fields).
// slave : the datapath and memory side.
interface multicycle_ctrl_if;
   // Instruction fields and datapath/memory status
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] alu_flags;
   logic       mem_ready;
   // Enables, mux selects and status from the sequencer
   logic       mem_req;
   logic       mem_we;
   logic       adr_src;
   logic       ir_write;
   logic       pc_write;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_control;
   logic [1:0] imm_src;
   logic [1:0] result_src;
   logic [3:0] flags;
   logic       busy;

   modport master (
      input  cond, op, funct, alu_flags, mem_ready,
      output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_control, imm_src, result_src, flags, busy
   );

   modport slave (
      output cond, op, funct, alu_flags, mem_ready,
      input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_control, imm_src, result_src, flags, busy
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM, NZCV flag
// register and memory request handshake.
// Optional feature macro: MULTICYCLE_COND_EXEC_EN enables ARM-style
// conditional execution in DECODE; without it every instruction executes.
module multicycle_ctrl #(
   parameter int unsigned FETCH_INC = 4
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);

   // FETCH_INC only documents the increment the datapath adder applies when
   // alu_src_b selects it; nothing in the sequencer depends on its value.
   if (FETCH_INC == 0) begin : g_zero_fetch_inc
   end

   typedef enum logic [3:0] {
      StFetch, StDecode, StExecR, StExecI, StAluWb,
      StMemAdr, StMemRd, StMemWr, StMemWb, StBranch
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic [1:0] imm_src_q, imm_d;

   logic [3:0] cmd;
   logic       cmd_ok, is_cmp, cond_ok;
   logic [1:0] alu_op;

   assign cmd       = bus.funct[4:1];
   assign bus.flags = flags_q;

`ifdef MULTICYCLE_COND_EXEC_EN
   // ARM condition codes over NZCV; 1111 never executes.
   function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = cf;
         4'b0011: cond_pass = !cf;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = cf && !z;
         4'b1001: cond_pass = !cf || z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z && (n == v);
         4'b1101: cond_pass = z || (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   assign cond_ok = cond_pass(bus.cond, flags_q);
`else
   assign cond_ok = 1'b1;
`endif

   // Data-processing command to ALU operation.
   always_comb begin
      alu_op = 2'b00;
      cmd_ok = 1'b1;
      is_cmp = 1'b0;
      case (cmd)
         4'b0100: alu_op = 2'b00;
         4'b0010: alu_op = 2'b01;
         4'b0000: alu_op = 2'b10;
         4'b1100: alu_op = 2'b11;
         4'b1010: begin
            alu_op = 2'b01;
            is_cmp = 1'b1;
         end
         default: cmd_ok = 1'b0;
      endcase
   end

   // State, flag and held imm_src registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         flags_q   <= 4'b0000;
         imm_src_q <= 2'b00;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         imm_src_q <= imm_d;
      end
   end

   // Next-state and per-state datapath controls; all forced low in reset.
   always_comb begin
      state_d         = state_q;
      flags_d         = flags_q;
      imm_d           = imm_src_q;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.adr_src     = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'd0;
      bus.alu_control = 2'b00;
      bus.result_src  = 2'd0;
      bus.busy        = (state_q != StFetch);

      case (state_q)
         StFetch: begin
            bus.mem_req    = 1'b1;
            bus.alu_src_b  = 2'd2;
            bus.result_src = 2'd2;
            if (bus.mem_ready) begin
               bus.ir_write = 1'b1;
               bus.pc_write = 1'b1;
               state_d      = StDecode;
            end
         end
         StDecode: begin
            if (!cond_ok || bus.op == 2'b11) state_d = StFetch;
            else if (bus.op == 2'b01)        state_d = StMemAdr;
            else if (bus.op == 2'b10)        state_d = StBranch;
            else if (bus.funct[5])           state_d = StExecI;
            else                             state_d = StExecR;
         end
         StExecR, StExecI: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_src_b   = (state_q == StExecI) ? 2'd1 : 2'd0;
            imm_d           = 2'd0;
            bus.alu_control = alu_op;
            if (bus.funct[0] || is_cmp) flags_d = bus.alu_flags;
            state_d = (is_cmp || !cmd_ok) ? StFetch : StAluWb;
         end
         StAluWb: begin
            bus.reg_write = 1'b1;
            state_d       = StFetch;
         end
         StMemAdr: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'd1;
            imm_d         = 2'd1;
            state_d       = bus.funct[0] ? StMemRd : StMemWr;
         end
         StMemRd: begin
            bus.mem_req = 1'b1;
            bus.adr_src = 1'b1;
            if (bus.mem_ready) state_d = StMemWb;
         end
         StMemWr: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = 1'b1;
            bus.adr_src = 1'b1;
            if (bus.mem_ready) state_d = StFetch;
         end
         StMemWb: begin
            bus.reg_write  = 1'b1;
            bus.result_src = 2'd1;
            state_d        = StFetch;
         end
         StBranch: begin
            bus.alu_src_b  = 2'd1;
            imm_d          = 2'd2;
            bus.result_src = 2'd2;
            bus.pc_write   = 1'b1;
            state_d        = StFetch;
         end
         default: state_d = StFetch;
      endcase

      bus.imm_src = imm_d;

      // Outputs follow rst_n combinationally so mem_req rises the moment
      // reset is released, and everything is quiet while it is held.
      if (!rst_n) begin
         bus.mem_req     = 1'b0;
         bus.mem_we      = 1'b0;
         bus.adr_src     = 1'b0;
         bus.ir_write    = 1'b0;
         bus.pc_write    = 1'b0;
         bus.reg_write   = 1'b0;
         bus.alu_src_a   = 1'b0;
         bus.alu_src_b   = 2'd0;
         bus.alu_control = 2'b00;
         bus.imm_src     = 2'd0;
         bus.result_src  = 2'd0;
         bus.busy        = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each cycle the packed control vector
// ctl is compared against a hand-written expectation.
// ctl field order: mem_req mem_we adr_src ir_write pc_write reg_write
//                  alu_src_a | alu_src_b[2] | alu_control[2] | imm_src[2] |
//                  result_src[2] | busy
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.FETCH_INC(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] ctl;
   assign ctl = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                 bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                 bus.imm_src, bus.result_src, bus.busy};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] e [2];
      e = '{16'b1_0_0_1_1_0_0_10_00_00_10_0, 16'b0_0_0_0_0_0_0_00_00_00_00_1};
      rst_n = 1'b0;
      bus.cond = 4'b1110; bus.op = 2'b11; bus.funct = 6'b0;
      bus.alu_flags = 4'b0; bus.mem_ready = 1'b1;
      #2;
      checks++;
      if (ctl !== 16'b0) begin
         failures++; $display("FAIL reset_outputs ctl=%b expected %b", ctl, 16'b0);
      end
      checks++;
      if (bus.flags !== 4'b0000) begin
         failures++; $display("FAIL reset_flags flags=%b expected 0000", bus.flags);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL reset_release cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL reset_undef_op busy=%b expected 0", bus.busy);
      end
   endtask

   // Data-processing instruction: FETCH, DECODE, EXEC (exec vector given),
   // optional ALUWB, then back to FETCH with the given flags.
   task automatic test_dp(input string name, input logic [5:0] funct, input logic [3:0] af,
                          input logic [15:0] exec_v, input logic wb, input logic [3:0] fl);
      logic [15:0] e [4];
      int n;
      e = '{16'b1_0_0_1_1_0_0_10_00_00_10_0, 16'b0_0_0_0_0_0_0_00_00_00_00_1, exec_v,
            16'b0_0_0_0_0_1_0_00_00_00_00_1};
      n = wb ? 4 : 3;
      bus.cond = 4'b1110; bus.op = 2'b00; bus.funct = funct; bus.alu_flags = af;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL %s cycle %0d ctl=%b expected %b", name, i, ctl, e[i]);
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.flags !== fl) begin
         failures++;
         $display("FAIL %s_end busy=%b flags=%b expected busy 0 flags %b", name, bus.busy,
                  bus.flags, fl);
      end
   endtask

   task automatic test_ldr_wait();
      logic [15:0] e [8];
      logic [7:0]  r;
      e = '{16'b1_0_0_1_1_0_0_10_00_00_10_0, 16'b0_0_0_0_0_0_0_00_00_00_00_1,
            16'b0_0_0_0_0_0_1_01_00_01_00_1, 16'b1_0_1_0_0_0_0_00_00_01_00_1,
            16'b1_0_1_0_0_0_0_00_00_01_00_1, 16'b1_0_1_0_0_0_0_00_00_01_00_1,
            16'b1_0_1_0_0_0_0_00_00_01_00_1, 16'b0_0_0_0_0_1_0_00_00_01_01_1};
      r = 8'b0100_0001;
      bus.cond = 4'b1110; bus.op = 2'b01; bus.funct = 6'b000001; bus.alu_flags = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         bus.mem_ready = r[i];
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL ldr_wait cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.flags !== 4'b0011) begin
         failures++;
         $display("FAIL ldr_end busy=%b flags=%b expected busy 0 flags 0011", bus.busy, bus.flags);
      end
   endtask

   task automatic test_str_fetch_wait();
      logic [15:0] e [5];
      logic [4:0]  r;
      e = '{16'b1_0_0_0_0_0_0_10_00_01_10_0, 16'b1_0_0_1_1_0_0_10_00_01_10_0,
            16'b0_0_0_0_0_0_0_00_00_01_00_1, 16'b0_0_0_0_0_0_1_01_00_01_00_1,
            16'b1_1_1_0_0_0_0_00_00_01_00_1};
      r = 5'b11110;
      bus.cond = 4'b1110; bus.op = 2'b01; bus.funct = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready = r[i];
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL str cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL str_end busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_cmp_beq();
      logic [15:0] e [6];
      e = '{16'b1_0_0_1_1_0_0_10_00_01_10_0, 16'b0_0_0_0_0_0_0_00_00_01_00_1,
            16'b0_0_0_0_0_0_1_00_01_00_00_1, 16'b1_0_0_1_1_0_0_10_00_00_10_0,
            16'b0_0_0_0_0_0_0_00_00_00_00_1, 16'b0_0_0_0_1_0_0_01_00_10_10_1};
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) begin
            bus.cond = 4'b1110; bus.op = 2'b00; bus.funct = 6'b010100; bus.alu_flags = 4'b0100;
         end else begin
            bus.cond = 4'b0000; bus.op = 2'b10; bus.funct = 6'b000000; bus.alu_flags = 4'b0000;
         end
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL cmp_beq cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         if (i == 2) begin
            tick();
            checks++;
            if (bus.busy !== 1'b0 || bus.flags !== 4'b0100) begin
               failures++;
               $display("FAIL cmp_end busy=%b flags=%b expected busy 0 flags 0100", bus.busy,
                        bus.flags);
            end
         end else begin
            tick();
         end
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.flags !== 4'b0100) begin
         failures++;
         $display("FAIL beq_end busy=%b flags=%b expected busy 0 flags 0100", bus.busy, bus.flags);
      end
   endtask

   task automatic test_bne_zset();
`ifdef MULTICYCLE_COND_EXEC_EN
      int n = 2;
`else
      int n = 3;
`endif
      logic [15:0] e [3];
      e = '{16'b1_0_0_1_1_0_0_10_00_10_10_0, 16'b0_0_0_0_0_0_0_00_00_10_00_1,
            16'b0_0_0_0_1_0_0_01_00_10_10_1};
      bus.cond = 4'b0001; bus.op = 2'b10; bus.funct = 6'b000000; bus.mem_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL bne cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         tick();
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++; $display("FAIL bne_end busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [15:0] e [5];
      logic [4:0]  r;
      e = '{16'b1_0_0_1_1_0_0_10_00_10_10_0, 16'b0_0_0_0_0_0_0_00_00_10_00_1,
            16'b0_0_0_0_0_0_1_01_00_01_00_1, 16'b1_1_1_0_0_0_0_00_00_01_00_1,
            16'b1_1_1_0_0_0_0_00_00_01_00_1};
      r = 5'b00001;
      bus.cond = 4'b1110; bus.op = 2'b01; bus.funct = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         bus.mem_ready = r[i];
         #1;
         checks++;
         if (ctl !== e[i]) begin
            failures++; $display("FAIL str_wait cycle %0d ctl=%b expected %b", i, ctl, e[i]);
         end
         if (i < 4) tick();
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctl !== 16'b0 || bus.flags !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset ctl=%b flags=%b expected all 0", ctl, bus.flags);
      end
      tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (ctl !== 16'b1_0_0_0_0_0_0_10_00_00_10_0) begin
         failures++;
         $display("FAIL post_reset_wait ctl=%b expected %b", ctl, 16'b1_0_0_0_0_0_0_10_00_00_10_0);
      end
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (ctl !== 16'b1_0_0_1_1_0_0_10_00_00_10_0) begin
         failures++;
         $display("FAIL post_reset_fetch ctl=%b expected %b", ctl, 16'b1_0_0_1_1_0_0_10_00_00_10_0);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++; $display("FAIL post_reset_decode busy=%b expected 1", bus.busy);
      end
   endtask

   initial begin
      test_reset();
      // ADD reg, ORR imm with S, AND imm, SUB reg with S, unsupported cmd
      test_dp("add_reg", 6'b001000, 4'b1111, 16'b0_0_0_0_0_0_1_00_00_00_00_1, 1'b1, 4'b0000);
      test_dp("orr_imm_s", 6'b111001, 4'b1010, 16'b0_0_0_0_0_0_1_01_11_00_00_1, 1'b1, 4'b1010);
      test_dp("and_imm", 6'b100000, 4'b1111, 16'b0_0_0_0_0_0_1_01_10_00_00_1, 1'b1, 4'b1010);
      test_dp("sub_reg_s", 6'b000101, 4'b0011, 16'b0_0_0_0_0_0_1_00_01_00_00_1, 1'b1, 4'b0011);
      test_dp("unsup_cmd", 6'b000010, 4'b1111, 16'b0_0_0_0_0_0_1_00_00_00_00_1, 1'b0, 4'b0011);
      test_ldr_wait();
      test_str_fetch_wait();
      test_cmp_beq();
      test_bne_zset();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control sequencer for the CalcuTEC core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the immediate-extension select (`imm_src`) and all datapath enables and muxes. It also owns the NZCV flag register and the memory request handshake, and sits between the instruction register and the shared datapath.

## Interface
Parameters:
- `FETCH_INC`, default 4: PC increment, informational only; the datapath ALU adds it when `alu_src_b`=2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cond` input 4: instr[31:28], the condition field.
- `op` input 2: instr[27:26]. 00 is data processing, 01 is memory, 10 is branch, 11 is undefined.
- `funct` input 6: instr[25:20]. [5] is I (immediate), [4:1] is cmd, [0] is S (data processing) or L (memory).
- `alu_flags` input 4: NZCV from the ALU in the current cycle.
- `mem_ready` input 1: memory has completed the access at this edge.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: write strobe, valid with `mem_req`.
- `adr_src` output 1: 0 selects PC, 1 selects the ALU result register.
- `ir_write` output 1: load the instruction register.
- `pc_write` output 1: load the PC.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: 0 selects the PC, 1 selects register A.
- `alu_src_b` output 2: 0 selects register B, 1 selects the extended immediate, 2 selects FETCH_INC.
- `alu_control` output 2: 00 add, 01 sub, 10 and, 11 orr.
- `imm_src` output 2: 0 is rotated data-processing immediate, 1 is memory offset, 2 is branch offset.
- `result_src` output 2: 0 selects the ALU result register, 1 selects memory data, 2 selects the raw ALU output.
- `flags` output 4: current NZCV register.
- `busy` output 1: high whenever the FSM is not in FETCH.

## Operation
States and transitions:
- FETCH: `mem_req`=1, `adr_src`=0, `alu_src_a`=0, `alu_src_b`=2, add, `result_src`=2.
  - Hold while `mem_ready`=0.
  - On `mem_ready`=1: `ir_write`=1 and `pc_write`=1 at the same edge, then go to DECODE.
- DECODE: evaluate the condition on the `flags` register.
  - Condition fail, or `op`=11: go to FETCH with no side effects.
  - `op`=01: go to MEMADR.
  - `op`=10: go to BRANCH.
  - `op`=00: go to EXECI if funct[5]=1, else EXECR.
- EXECR / EXECI: `alu_src_a`=1, `alu_src_b`=0 (EXECR) or 1 (EXECI), `imm_src`=0.
  - cmd→ALU: 0100 ADD→00, 0010 SUB→01, 0000 AND→10, 1100 ORR→11, 1010 CMP→01.
  - `flags` ← `alu_flags` at the exit edge if S=1 or cmd=CMP.
  - CMP and unsupported cmd go to FETCH.
  - All other supported cmd go to ALUWB.
- ALUWB: `reg_write`=1, `result_src`=0, then go to FETCH.
- MEMADR: `alu_src_a`=1, `alu_src_b`=1, `imm_src`=1, add. Go to MEMRD if L=1, else MEMWR.
- MEMRD: `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWR: `mem_req`=1, `mem_we`=1, `adr_src`=1. Hold until `mem_ready`, then go to FETCH.
- MEMWB: `reg_write`=1, `result_src`=1, then go to FETCH.
- BRANCH: `alu_src_a`=0, `alu_src_b`=1, `imm_src`=2, add, `result_src`=2, `pc_write`=1, then go to FETCH.

Rules:
- Every output not listed for a state is 0, except `imm_src`, which holds its last value outside the states that set it.
- Condition codes follow the ARM encoding 0000–1110. Code 1111 always fails.
- `mem_req` and `mem_we` stay stable for the whole wait; the address mux does not change until `mem_ready`.

## Timing
- Reset, asserted at any time including mid-wait:
  - state is FETCH and `flags` is 0000;
  - every output is 0, except `mem_req`, which is 1 immediately after reset deasserts.
- Latency with `mem_ready` tied high:
  - ADD / SUB / AND / ORR: 4 cycles.
  - CMP: 3 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Condition-failed instruction: 2 cycles.
- Each memory wait cycle adds 1 cycle.
- `flags` written in EXEC are visible to the next instruction's DECODE.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.

## Configuration
- `MULTICYCLE_COND_EXEC_EN` defined: condition evaluation as described above.
- Not defined: every instruction executes unconditionally, DECODE ignores `cond`, and `flags` still updates.

## Test plan
- Reset release with `mem_ready`=1 → `mem_req`=1 in the first cycle, `ir_write` and `pc_write` pulse at the first edge, `busy`=1 in the next cycle.
- ADD register (`op`=00, `funct`=001000, cond=1110) → DECODE, EXECR with `alu_control`=00, ALUWB with `reg_write`=1; 4 cycles total.
- LDR (`op`=01, `funct`=000001) with `mem_ready` low for 3 cycles in MEMRD → `mem_req`/`adr_src`=1 held for 4 cycles, then MEMWB with `result_src`=1; 8 cycles total.
- CMP with `alu_flags`=0100, then BEQ (cond=0000, `op`=10) → `flags`=0100, BRANCH with `imm_src`=2 and `pc_write`=1.
- BNE (cond=0001) with Z=1 → DECODE returns to FETCH, no `pc_write` after the fetch; without the macro, BRANCH is taken.
- `rst_n` low during a MEMWR wait → all outputs 0 and `flags`=0000 immediately, FETCH resumes after release.
